// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, NREAD packed
// read ports, the link-register view and the clear-sweep handshake.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   ena;
  logic                   we0;
  logic [AW-1:0]          waddr0;
  logic [WIDTH-1:0]       wdata0;
  logic                   we1;
  logic [AW-1:0]          waddr1;
  logic [WIDTH-1:0]       wdata1;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [WIDTH-1:0]       reg_link;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output ena, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    input  rdata, reg_link, clr_busy, clr_done
  );

  modport slave (
    input  ena, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    output rdata, reg_link, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write CPU register file with a sequential clear sweep.
// Port 0 is the general writeback port, port 1 the link port (wins on an
// address collision). Reads are combinational. A clear request sweeps one
// register per cycle; port writes arriving during the sweep are dropped.
// Optional feature: define RF_BYPASS_EN to forward same-cycle accepted write
// data to matching read ports.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 31
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic        ZR       = (ZERO_REG != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state;
  logic [AW:0]      idx;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok0;
  logic             wr_ok1;
  logic [NREAD*WIDTH-1:0] rdata_c;

  // Address is backed by a real, writable/readable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZR && (a == '0));
  endfunction

  // Write acceptance; port 1 claims the address when both ports collide.
  always_comb begin
    wr_ok1 = bus.ena && (state == IDLE) && bus.we1 && addr_ok(bus.waddr1);
    wr_ok0 = bus.ena && (state == IDLE) && bus.we0 && addr_ok(bus.waddr0) &&
             !(wr_ok1 && (bus.waddr1 == bus.waddr0));
  end

  // Clear-sweep controller: walks idx from 0 to DEPTH-1, then pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: sweep clears take precedence over port writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[idx[AW-1:0]] <= '0;
    end else begin
      if (wr_ok0) mem[bus.waddr0] <= bus.wdata0;
      if (wr_ok1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = bus.raddr[k*AW +: AW];

    // Read mux: gated by ena, unbacked addresses and r0 read as zero.
    always_comb begin
      rd = '0;
      if (bus.ena && addr_ok(ra)) begin
        rd = mem[ra];
`ifdef RF_BYPASS_EN
        if (wr_ok1 && (bus.waddr1 == ra)) begin
          rd = bus.wdata1;
        end else if (wr_ok0 && (bus.waddr0 == ra)) begin
          rd = bus.wdata0;
        end
`endif
      end
    end

    assign rdata_c[k*WIDTH +: WIDTH] = rd;
  end

  assign bus.rdata    = rdata_c;
  assign bus.reg_link = mem[LINK_REG];
  assign bus.clr_busy = busy;
  assign bus.clr_done = done;
endmodule
